// File: rtl/game_timer_arbiter.sv
// game_timer_arbiter: one prescaled countdown timer shared round-robin by
// NUM_REQ game-logic requesters (level delay, respawn delay, invulnerability).
// Each requester posts a duration in ticks and gets a one-cycle expire pulse
// when its granted countdown completes.
module game_timer_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int TICK_DIV = 500000,
  parameter int DUR_W    = 11
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     pause,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DUR_W-1:0] dur,
  input  logic [NUM_REQ-1:0]       cancel,
  output logic [NUM_REQ-1:0]       expire,
  output logic [NUM_REQ-1:0]       pending,
  output logic                     busy,
  output logic [1:0]               active_id,
  output logic [DUR_W-1:0]         remaining
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

  state_t               state_q;
  logic [NUM_REQ-1:0]   pending_q;
  logic [NUM_REQ-1:0]   pending_d;
  logic [NUM_REQ-1:0]   expire_q;
  logic [DUR_W-1:0]     dur_q [NUM_REQ];
  logic [DUR_W-1:0]     dur_d [NUM_REQ];
  logic [1:0]           active_id_q;
  logic [1:0]           rr_q;
  logic [DUR_W-1:0]     remaining_q;
  logic [PRE_W-1:0]     presc_q;
  logic                 active_live;
  logic [3:0]           eligible;
  logic                 grant_vld;
  logic [1:0]           grant_idx;

  // A zero duration would never reach the remaining==1 completion point.
  function automatic logic [DUR_W-1:0] norm_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  // (base + off) mod NUM_REQ for off in 1..NUM_REQ.
  function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return 2'(s);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] sel);
    logic [3:0] t;
    t = 4'b0001 << sel;
    return t[NUM_REQ-1:0];
  endfunction

  assign active_live = (state_q == LOAD) || (state_q == COUNT);

  // Latch new requests, honour cancels (cancel beats req), drop the granted bit in LOAD.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      dur_d[i] = dur_q[i];
      if (cancel[i]) begin
        pending_d[i] = 1'b0;
      end else if (req[i] && !pending_q[i] &&
                   !(active_live && (active_id_q == 2'(i)))) begin
        pending_d[i] = 1'b1;
        dur_d[i]     = norm_dur(dur[i*DUR_W +: DUR_W]);
      end
    end
    if (state_q == LOAD) pending_d[active_id_q] = 1'b0;
  end

  // Round-robin pick: first eligible index after rr_q, wrapping back to rr_q last.
  always_comb begin
    eligible  = 4'(pending_q & ~cancel);
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (eligible[wrap_idx(rr_q, off)]) begin
        grant_vld = 1'b1;
        grant_idx = wrap_idx(rr_q, off);
      end
    end
  end

  // Request table registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) dur_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      for (int i = 0; i < NUM_REQ; i++) dur_q[i] <= dur_d[i];
    end
  end

  // Timer FSM. DONE also arbitrates so a queued request reaches LOAD without
  // an extra idle cycle, keeping back-to-back expires 2 + dur*TICK_DIV apart.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      expire_q    <= '0;
      active_id_q <= 2'd0;
      rr_q        <= 2'd0;
      remaining_q <= '0;
      presc_q     <= '0;
    end else begin
      expire_q <= '0;
      unique case (state_q)
        IDLE: begin
          remaining_q <= '0;
          if (grant_vld) begin
            active_id_q <= grant_idx;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          if (cancel[active_id_q]) begin
            remaining_q <= '0;
            state_q     <= IDLE;
          end else begin
            remaining_q <= dur_q[active_id_q];
            presc_q     <= '0;
            rr_q        <= active_id_q;
            state_q     <= COUNT;
          end
        end
        COUNT: begin
          if (cancel[active_id_q]) begin
            remaining_q <= '0;
            presc_q     <= '0;
            state_q     <= IDLE;
          end else if (!pause) begin
            if (presc_q == PRE_LAST) begin
              presc_q <= '0;
              if (remaining_q == DUR_W'(1)) begin
                remaining_q <= '0;
                expire_q    <= onehot(active_id_q);
                state_q     <= DONE;
              end else begin
                remaining_q <= remaining_q - 1'b1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
        end
        DONE: begin
          remaining_q <= '0;
          if (grant_vld) begin
            active_id_q <= grant_idx;
            state_q     <= LOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign expire    = expire_q;
  assign pending   = pending_q;
  assign busy      = (state_q != IDLE);
  assign active_id = active_id_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_game_timer_arbiter.sv
// Directed bench for game_timer_arbiter with TICK_DIV=4, NUM_REQ=3.
module tb_game_timer_arbiter;

  localparam int NUM_REQ  = 3;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 11;

  logic                     clk = 1'b0;
  logic                     resetN = 1'b0;
  logic                     pause = 1'b0;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*DUR_W-1:0] dur = '0;
  logic [NUM_REQ-1:0]       cancel = '0;
  logic [NUM_REQ-1:0]       expire;
  logic [NUM_REQ-1:0]       pending;
  logic                     busy;
  logic [1:0]               active_id;
  logic [DUR_W-1:0]         remaining;

  int vectors = 0;
  int miscompares = 0;
  logic [NUM_REQ-1:0] exp_seen;

  always #5 clk = ~clk;

  game_timer_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TICK_DIV(TICK_DIV),
    .DUR_W   (DUR_W)
  ) dut (
    .clk      (clk),
    .resetN   (resetN),
    .pause    (pause),
    .req      (req),
    .dur      (dur),
    .cancel   (cancel),
    .expire   (expire),
    .pending  (pending),
    .busy     (busy),
    .active_id(active_id),
    .remaining(remaining)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_dur(input int idx, input int val);
    dur[idx*DUR_W +: DUR_W] = DUR_W'(val);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_expire", 32'(expire), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_active", 32'(active_id), 0);
    chk("rst_remaining", 32'(remaining), 0);
    @(posedge clk); #1;
    resetN = 1'b1;
    step(1);

    // single request, dur=3
    req = 3'b001; set_dur(0, 3);
    step(1);
    chk("t1_pending", 32'(pending), 32'b001);
    req = '0;
    step(1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_active", 32'(active_id), 0);
    step(1);
    chk("t1_rem3", 32'(remaining), 3);
    chk("t1_pend_clr", 32'(pending), 0);
    step(3);
    chk("t1_rem3_hold", 32'(remaining), 3);
    step(1);
    chk("t1_rem2", 32'(remaining), 2);
    step(7);
    chk("t1_rem1", 32'(remaining), 1);
    chk("t1_noexp", 32'(expire), 0);
    step(1);
    chk("t1_expire", 32'(expire), 32'b001);
    chk("t1_rem0", 32'(remaining), 0);
    step(1);
    chk("t1_exp_off", 32'(expire), 0);
    chk("t1_idle", 32'(busy), 0);

    // arbitration, all three at once, dur=1, rr=0
    req = 3'b111; set_dur(0, 1); set_dur(1, 1); set_dur(2, 1);
    step(1);
    chk("t2_pending", 32'(pending), 32'b111);
    req = '0;
    step(1);
    chk("t2_grant1", 32'(active_id), 1);
    step(5);
    chk("t2_exp1", 32'(expire), 32'b010);
    step(1);
    chk("t2_grant2", 32'(active_id), 2);
    chk("t2_exp1_off", 32'(expire), 0);
    step(5);
    chk("t2_exp2", 32'(expire), 32'b100);
    step(1);
    chk("t2_grant0", 32'(active_id), 0);
    step(4);
    chk("t2_noexp", 32'(expire), 0);
    step(1);
    chk("t2_exp0", 32'(expire), 32'b001);
    step(1);
    chk("t2_idle", 32'(busy), 0);

    // pause for 7 cycles mid-count, dur=2
    req = 3'b100; set_dur(2, 2);
    step(1);
    chk("t3_pending", 32'(pending), 32'b100);
    req = '0;
    step(1);
    chk("t3_grant2", 32'(active_id), 2);
    step(2);
    pause = 1'b1;
    step(2);
    chk("t3_pause_rem_a", 32'(remaining), 2);
    step(5);
    chk("t3_pause_rem_b", 32'(remaining), 2);
    pause = 1'b0;
    step(6);
    chk("t3_rem1", 32'(remaining), 1);
    chk("t3_noexp", 32'(expire), 0);
    step(1);
    chk("t3_expire", 32'(expire), 32'b100);
    step(1);
    chk("t3_idle", 32'(busy), 0);

    // cancel the active request at remaining=2
    req = 3'b011; set_dur(0, 3); set_dur(1, 1);
    step(1);
    chk("t4_pending", 32'(pending), 32'b011);
    req = '0;
    step(1);
    chk("t4_grant0", 32'(active_id), 0);
    step(5);
    chk("t4_rem2", 32'(remaining), 2);
    cancel = 3'b001;
    step(1);
    chk("t4_cancel_idle", 32'(busy), 0);
    chk("t4_cancel_rem", 32'(remaining), 0);
    chk("t4_cancel_noexp", 32'(expire), 0);
    chk("t4_cancel_pend", 32'(pending), 32'b010);
    cancel = '0;
    step(1);
    chk("t4_grant1", 32'(active_id), 1);
    chk("t4_busy", 32'(busy), 1);
    step(5);
    chk("t4_exp1", 32'(expire), 32'b010);
    step(1);
    chk("t4_idle", 32'(busy), 0);

    // cancel and req together: nothing latched
    req = 3'b100; cancel = 3'b100; set_dur(2, 5);
    step(1);
    chk("t4_cr_pending", 32'(pending), 0);
    req = '0; cancel = '0;
    step(1);
    chk("t4_cr_idle", 32'(busy), 0);

    // duplicate request while active is ignored
    req = 3'b010; set_dur(1, 5);
    step(1);
    req = '0;
    step(3);
    req = 3'b010; set_dur(1, 1);
    step(1);
    chk("t5_dup_pending", 32'(pending), 0);
    req = '0;
    step(14);
    chk("t5_rem1", 32'(remaining), 1);
    step(3);
    chk("t5_noexp", 32'(expire), 0);
    step(1);
    chk("t5_expire", 32'(expire), 32'b010);
    step(1);
    chk("t5_idle", 32'(busy), 0);
    step(1);
    chk("t5_no_regrant", 32'(busy), 0);

    // zero duration counts as one tick
    req = 3'b001; set_dur(0, 0);
    step(1);
    req = '0;
    step(2);
    chk("t5_zero_rem", 32'(remaining), 1);
    step(3);
    chk("t5_zero_noexp", 32'(expire), 0);
    step(1);
    chk("t5_zero_exp", 32'(expire), 32'b001);
    step(1);

    // async reset mid-count
    req = 3'b100; set_dur(2, 4);
    step(1);
    req = '0;
    step(3);
    req = 3'b001; set_dur(0, 2);
    step(1);
    req = '0;
    chk("t6_pending", 32'(pending), 32'b001);
    chk("t6_rem4", 32'(remaining), 4);
    chk("t6_active", 32'(active_id), 2);
    #3;
    resetN = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_rem", 32'(remaining), 0);
    chk("t6_rst_pending", 32'(pending), 0);
    chk("t6_rst_active", 32'(active_id), 0);
    chk("t6_rst_expire", 32'(expire), 0);
    @(posedge clk); #1;
    resetN = 1'b1;
    exp_seen = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      exp_seen = exp_seen | expire;
    end
    chk("t6_no_expire", 32'(exp_seen), 0);
    chk("t6_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
